// File: rtl/param_stack_if.sv
// param_stack_if: push/pop handshake and status bundle for param_stack
// Parameters: DATA_W word width, DEPTH entries; CNT_W is the derived count width.
// master drives push, pop, din and clr_err; slave drives dout, dout_valid,
// count, full, empty, overflow, underflow and hwm.
interface param_stack_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  logic              push;
  logic              pop;
  logic              clr_err;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;
  logic [CNT_W-1:0]  hwm;
  modport master (
    output push, pop, clr_err, din,
    input  dout, dout_valid, count, full, empty, overflow, underflow, hwm
  );
  modport slave (
    input  push, pop, clr_err, din,
    output dout, dout_valid, count, full, empty, overflow, underflow, hwm
  );
endinterface

// File: rtl/param_stack.sv
// param_stack: parametrised LIFO with sticky overflow/underflow flags
// Ports: clk, rst (sync, active-high), bus (param_stack_if.slave).
// Optional build macro PARAM_STACK_HWM_EN adds a high-water-mark register on
// bus.hwm; without it bus.hwm is tied to 0.
module param_stack #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input logic          clk,
  input logic          rst,
  param_stack_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IW    = $clog2(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              full, empty, replace, push_ok, pop_ok;
  logic [IW-1:0]     top, wa;
  assign full    = count_q == CNT_W'(DEPTH);
  assign empty   = count_q == '0;
  // push+pop on a non-empty stack swaps the top word instead of moving count
  assign replace = bus.push & bus.pop & ~empty;
  // push+pop on empty still accepts the push; only the pop is rejected
  assign push_ok = bus.push & (bus.pop ? empty : ~full);
  assign pop_ok  = bus.pop & ~bus.push & ~empty;
  assign top     = IW'(count_q - CNT_W'(1));
  assign wa      = replace ? top : IW'(count_q);
  always_comb begin
    mem_d = mem_q;
    if (!rst && (push_ok || replace)) mem_d[wa] = bus.din;
    count_d      = rst ? '0 : push_ok ? count_q + CNT_W'(1) : pop_ok ? count_q - CNT_W'(1) : count_q;
    dout_d       = rst ? '0 : (replace | pop_ok) ? mem_q[top] : dout_q;
    dout_valid_d = ~rst & (replace | pop_ok);
    overflow_d   = ~rst & ~bus.clr_err & (overflow_q | (bus.push & ~bus.pop & full));
    underflow_d  = ~rst & ~bus.clr_err & (underflow_q | (bus.pop & empty));
  end
  always_ff @(posedge clk) begin
    mem_q        <= mem_d;
    count_q      <= count_d;
    dout_q       <= dout_d;
    dout_valid_q <= dout_valid_d;
    overflow_q   <= overflow_d;
    underflow_q  <= underflow_d;
  end
`ifdef PARAM_STACK_HWM_EN
  logic [CNT_W-1:0] hwm_q, hwm_d;
  always_comb hwm_d = rst ? '0 : (count_d > hwm_q) ? count_d : hwm_q;
  always_ff @(posedge clk) hwm_q <= hwm_d;
  assign bus.hwm = hwm_q;
`else
  assign bus.hwm = '0;
`endif
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.count      = count_q;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;
endmodule
